// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add/subtract sequenced through one 4-bit adder slice,
// least-significant nibble first, with valid/ready handshakes on operands and result.
module adder_4_bit (
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       Cin,
    output logic [3:0] Z,
    output logic       Cout
);
    assign {Cout, Z} = {1'b0, X} + {1'b0, Y} + {4'b0, Cin};
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             op,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW = $clog2(NIBBLES);

    generate
        if (WIDTH % 4 != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, next;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic            carry_reg;
    logic [3:0]      z;
    logic            cout_s;
    logic            last;

    adder_4_bit u_slice (
        .X   (a_reg[4*cnt +: 4]),
        .Y   (b_reg[4*cnt +: 4]),
        .Cin (carry_reg),
        .Z   (z),
        .Cout(cout_s)
    );

    assign last = cnt == CW'(NIBBLES - 1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next      = (state == IDLE) ? (in_valid ? RUN : IDLE) :
                    (state == RUN)  ? (last ? DONE : RUN) :
                                      (out_ready ? IDLE : DONE);
        in_ready  = state == IDLE;
        busy      = state != IDLE;
        out_valid = state == DONE;
    end

    // Subtract is A + ~B + 1, so the inversion and forced carry happen at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            SUM       <= '0;
            COUT      <= 1'b0;
            OVF       <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_reg     <= A;
            b_reg     <= op ? ~B : B;
            carry_reg <= op ? 1'b1 : Cin;
            cnt       <= '0;
            SUM       <= '0;
        end else if (state == RUN) begin
            SUM[4*cnt +: 4] <= z;
            carry_reg       <= cout_s;
            cnt             <= last ? '0 : cnt + 1'b1;
            if (last) begin
                COUT <= cout_s;
                OVF  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (z[3] != a_reg[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed tests of the nibble-serial adder controller at WIDTH=16.
module tb_nibble_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, Cin, op, busy, out_valid, out_ready, COUT, OVF;
    logic [15:0] A, B, SUM;
    int          checks = 0;
    int          errors = 0;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .Cin(Cin), .op(op), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .SUM(SUM), .COUT(COUT), .OVF(OVF)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accepts one operation, scrambles the operand inputs, waits (bounded) for out_valid,
    // captures the result and takes one more edge so out_ready can complete the handshake.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic o,
                          output logic [15:0] s, output logic co, output logic ov,
                          output int lat, output int bc);
        A = a; B = b; Cin = c; op = o; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; A = ~a; B = ~b; Cin = ~c; op = ~o;
        lat = 0; bc = 0;
        while (!out_valid && lat < 20) begin
            bc += int'(busy);
            tick;
            lat++;
        end
        s = SUM; co = COUT; ov = OVF;
        bc += int'(busy);
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b busy=%b out_valid=%b, want 1 0 0", in_ready, busy, out_valid);
        end
        checks++;
        if (SUM !== 16'h0 || COUT !== 1'b0 || OVF !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: SUM=%h COUT=%b OVF=%b, want 0000 0 0", SUM, COUT, OVF);
        end
    endtask

    task automatic test_add_ripple;
        logic [15:0] s; logic co, ov; int lat, bc;
        out_ready = 1'b1;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, bc);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL add_latency: %0d cycles, want 4", lat);
        end
        checks++;
        if (s !== 16'h0000 || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL add_ripple: SUM=%h COUT=%b OVF=%b, want 0000 1 0", s, co, ov);
        end
        checks++;
        if (bc !== 5 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_busy: busy cycles=%0d busy=%b out_valid=%b, want 5 0 0", bc, busy, out_valid);
        end
    endtask

    task automatic test_subtract;
        logic [15:0] s; logic co, ov; int lat, bc;
        run_op(16'h1234, 16'h0235, 1'b1, 1'b1, s, co, ov, lat, bc);
        checks++;
        if (s !== 16'h0FFF || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL sub_basic: SUM=%h COUT=%b OVF=%b, want 0fff 1 0", s, co, ov);
        end
        run_op(16'h0000, 16'h0001, 1'b0, 1'b1, s, co, ov, lat, bc);
        checks++;
        if (s !== 16'hFFFF || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: SUM=%h COUT=%b OVF=%b, want ffff 0 0", s, co, ov);
        end
    endtask

    task automatic test_overflow;
        logic [15:0] s; logic co, ov; int lat, bc;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, bc);
        checks++;
        if (s !== 16'h8000 || co !== 1'b0 || ov !== 1'b1) begin
            errors++;
            $display("FAIL ovf_add: SUM=%h COUT=%b OVF=%b, want 8000 0 1", s, co, ov);
        end
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, ov, lat, bc);
        checks++;
        if (s !== 16'h7FFF || co !== 1'b1 || ov !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sub: SUM=%h COUT=%b OVF=%b, want 7fff 1 1", s, co, ov);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        A = 16'h1234; B = 16'h1111; Cin = 1'b1; op = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            A = 16'h0F0F; B = 16'h0101; in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready: cycle %0d in_ready=%b, want 0", i, in_ready);
            end
            tick;
            checks++;
            if (out_valid !== 1'b1 || SUM !== 16'h2346 || COUT !== 1'b0 || OVF !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d out_valid=%b SUM=%h COUT=%b OVF=%b, want 1 2346 0 0",
                         i, out_valid, SUM, COUT, OVF);
            end
        end
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || SUM !== 16'h2346) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b SUM=%h, want 0 1 0 2346",
                     out_valid, in_ready, busy, SUM);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] s; logic co, ov; int lat, bc;
        out_ready = 1'b1;
        A = 16'hABCD; B = 16'h1111; Cin = 1'b0; op = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (SUM !== 16'h0 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: SUM=%h busy=%b out_valid=%b in_ready=%b, want 0000 0 0 1",
                     SUM, busy, out_valid, in_ready);
        end
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, s, co, ov, lat, bc);
        checks++;
        if (s !== 16'h0007 || co !== 1'b0 || ov !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL rst_next_op: SUM=%h COUT=%b OVF=%b lat=%0d, want 0007 0 0 4", s, co, ov, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ta [3] = '{16'h0001, 16'hF0F0, 16'h5000};
        logic [15:0] tb [3] = '{16'h0002, 16'h0F10, 16'h6000};
        logic        to [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] es [3] = '{16'h0003, 16'h0000, 16'hF000};
        logic        ec [3] = '{1'b0, 1'b1, 1'b0};
        int acc_t [3];
        int acc = 0, res = 0, cyc = 0, extra = 0;
        logic take;
        out_ready = 1'b1;
        A = ta[0]; B = tb[0]; op = to[0]; Cin = 1'b0; in_valid = 1'b1;
        while ((acc < 3 || res < 3) && cyc < 60) begin
            take = in_ready && in_valid;
            tick;
            cyc++;
            if (take) begin
                acc_t[acc] = cyc;
                acc++;
                if (acc < 3) begin
                    A = ta[acc]; B = tb[acc]; op = to[acc];
                end else in_valid = 1'b0;
            end
            if (out_valid) begin
                if (res < 3) begin
                    checks++;
                    if (SUM !== es[res] || COUT !== ec[res]) begin
                        errors++;
                        $display("FAIL b2b_result%0d: SUM=%h COUT=%b, want %h %b", res, SUM, COUT, es[res], ec[res]);
                    end
                end
                res++;
            end
        end
        in_valid = 1'b0;
        repeat (8) begin
            tick;
            extra += int'(out_valid);
        end
        checks++;
        if (acc !== 3 || res !== 3 || extra !== 0) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d results=%0d extra=%0d, want 3 3 0", acc, res, extra);
        end
        checks++;
        if (acc == 3 && (acc_t[1] - acc_t[0] !== 6 || acc_t[2] - acc_t[1] !== 6)) begin
            errors++;
            $display("FAIL b2b_spacing: gaps %0d %0d, want 6 6", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; op = 1'b0; out_ready = 1'b0;
        test_reset;
        test_add_ripple;
        test_subtract;
        test_overflow;
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencing controller that computes WIDTH-bit add/subtract by time-multiplexing one internal 4-bit adder slice (Adder_4_bit: X, Y, Cin -> Z, Cout) over WIDTH/4 cycles.
- Least-significant nibble first; a registered carry is passed between nibbles.
- Valid/ready handshake on both the operand side and the result side.
- Used where area matters more than throughput; one operation is in flight at a time.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8; elaborate-time error otherwise.
- NIBBLES, WIDTH/4, derived local constant giving the number of slice cycles per operation.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  controller can accept operands (IDLE only).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in for add; ignored for subtract.
- op  input  1  0 = A+B+Cin, 1 = A-B (two's complement).
- busy  output  1  high in RUN and DONE.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- SUM  output  WIDTH  result.
- COUT  output  1  final carry out (for subtract, 1 means no borrow).
- OVF  output  1  signed overflow flag.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; cnt, A_reg, B_reg, carry_reg, SUM, COUT and OVF all 0; out_valid=0, busy=0, in_ready=1 after that edge. Reset has priority over every other event, including mid-RUN and mid-DONE; the in-flight operation is discarded with no partial result.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch A_reg=A. Latch B_reg=B if op=0, else B_reg=~B. Set carry_reg=Cin if op=0, else 1.
  - On the same edge: cnt=0, SUM cleared to 0, go to RUN.
  - in_valid=0: stay in IDLE.
- RUN (in_ready=0, busy=1), one nibble per cycle:
  - Slice inputs: X=A_reg[4*cnt+:4], Y=B_reg[4*cnt+:4], Cin=carry_reg.
  - At the edge: SUM[4*cnt+:4]=Z, carry_reg=Cout, cnt=cnt+1.
  - When cnt==NIBBLES-1 at the edge: go to DONE. At that edge COUT=Cout and OVF=(A_reg[WIDTH-1]==B_reg[WIDTH-1]) && (Z[3]!=A_reg[WIDTH-1]). cnt wraps to 0.
  - in_valid is ignored in RUN; operands may change freely after acceptance.
- DONE (out_valid=1, busy=1):
  - SUM, COUT and OVF are held stable until out_ready=1 at an edge, then go to IDLE with out_valid=0.
  - out_ready held high: out_valid lasts exactly one cycle.
  - There is no IDLE bypass. Next accept is at the earliest on the edge after returning to IDLE, so throughput is one operation per NIBBLES+2 cycles.
- Latency: accept edge at k; out_valid goes high after edge k+NIBBLES (4 cycles for WIDTH=16).
- SUM, COUT and OVF retain the last result in IDLE until the next accept clears SUM. Only out_valid qualifies them.
- out_ready outside DONE has no effect. in_valid and out_ready asserted simultaneously in DONE: only the result handshake occurs.
- Width rule: all arithmetic is modulo 2^WIDTH; the carry beyond the MSB appears only on COUT.

Test Plan (WIDTH=16):
- Add with full carry ripple: A=0xFFFF, B=0x0001, op=0, Cin=0 -> SUM=0x0000, COUT=1, OVF=0. out_valid rises exactly 4 cycles after the accept edge; busy high for 5 cycles with out_ready=1.
- Subtract with Cin ignored: A=0x1234, B=0x0235, op=1, Cin=1 -> SUM=0x0FFF, COUT=1, OVF=0. Repeat with A=0x0000, B=0x0001 -> SUM=0xFFFF, COUT=0.
- Signed overflow:
  - A=0x7FFF, B=0x0001, op=0 -> SUM=0x8000, OVF=1, COUT=0.
  - A=0x8000, B=0x0001, op=1 -> SUM=0x7FFF, OVF=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and SUM/COUT/OVF stay stable. in_valid pulses during DONE are not accepted (in_ready=0). out_ready=1 -> return to IDLE on the next edge.
- Reset mid-operation: accept A=0xABCD, B=0x1111, assert rst after 2 RUN cycles -> on the next edge SUM=0, busy=0, out_valid=0, in_ready=1. The next operation, 0x0003+0x0004, gives SUM=0x0007 with no stale carry.
- Back-to-back: in_valid held high with out_ready=1, 3 operations -> accepts spaced exactly 6 cycles apart, each result correct, no lost or duplicated out_valid.
